// File: rtl/mpu_pkg.sv
// MPU sample unpack shared types and helpers.
// Burst layout, word indices and gyro saturation.
package mpu_pkg;

    localparam int MPU_BURST_BYTES = 14;
    localparam int MPU_WORDS       = MPU_BURST_BYTES / 2;

    localparam int IDX_AX   = 0;
    localparam int IDX_AY   = 1;
    localparam int IDX_AZ   = 2;
    localparam int IDX_TEMP = 3;
    localparam int IDX_GX   = 4;
    localparam int IDX_GY   = 5;
    localparam int IDX_GZ   = 6;

    typedef logic signed [15:0] sample_t;

    // High byte arrives first in the burst.
    function automatic sample_t mpu_word(
        input logic [8*MPU_BURST_BYTES-1:0] pack,
        input int                           idx
    );
        return {pack[16*idx +: 8], pack[16*idx+8 +: 8]};
    endfunction

    function automatic sample_t sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7fff;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/mpu_sample_unpack_if.sv
// Burst delivery bus from the MPU I2C reader.
// The reader drives it; the unpacker consumes it.
interface mpu_sample_unpack_if;
    import mpu_pkg::*;

    logic                         mpu_read_done;
    logic [8*MPU_BURST_BYTES-1:0] mpu_data_pack;
    logic                         mpu_error;

    modport master (
        output mpu_read_done,
        output mpu_data_pack,
        output mpu_error
    );

    modport slave (
        input mpu_read_done,
        input mpu_data_pack,
        input mpu_error
    );

endinterface

// File: rtl/mpu_gyro_calib.sv
// Gyro bias calibration: averages 2^CALIB_SHIFT samples
// per axis and commits the result as the new bias.
module mpu_gyro_calib
    import mpu_pkg::*;
#(
    parameter int CALIB_SHIFT = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    smp_valid,
    input  logic    start,
    input  logic    error,
    input  sample_t gx,
    input  sample_t gy,
    input  sample_t gz,
    output sample_t bias_x,
    output sample_t bias_y,
    output sample_t bias_z,
    output logic    calib_busy,
    output logic    calib_done,
    output logic    calib_fail
);

    localparam int AW = 16 + CALIB_SHIFT;
    localparam int CW = CALIB_SHIFT + 1;
    localparam logic [CW-1:0] FULL = CW'(1) << CALIB_SHIFT;

    typedef enum logic {
        ST_RUN,
        ST_CALIB
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic done_q, done_d;
    logic fail_q, fail_d;

    sample_t g [3];
    sample_t bias_q [3];
    sample_t bias_d [3];
    logic signed [AW-1:0] acc_q [3];
    logic signed [AW-1:0] acc_d [3];
    logic signed [AW-1:0] acc_nxt [3];
    logic signed [AW-1:0] avg [3];

    assign g[0] = gx;
    assign g[1] = gy;
    assign g[2] = gz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        cnt_nxt = cnt_q + CW'(1);
        for (int i = 0; i < 3; i++) begin
            acc_d[i]   = acc_q[i];
            bias_d[i]  = bias_q[i];
            acc_nxt[i] = acc_q[i] + AW'(g[i]);
            avg[i]     = acc_nxt[i] >>> CALIB_SHIFT;
        end
        unique case (state_q)
            ST_RUN: begin
                if (start) begin
                    state_d = ST_CALIB;
                    cnt_d   = '0;
                    for (int i = 0; i < 3; i++) acc_d[i] = '0;
                end
            end
            ST_CALIB: begin
                // Error beats restart and beats the final sample.
                if (error) begin
                    state_d = ST_RUN;
                    fail_d  = 1'b1;
                end else if (start) begin
                    cnt_d = '0;
                    for (int i = 0; i < 3; i++) acc_d[i] = '0;
                end else if (smp_valid) begin
                    cnt_d = cnt_nxt;
                    for (int i = 0; i < 3; i++) acc_d[i] = acc_nxt[i];
                    if (cnt_nxt == FULL) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            bias_d[i] = avg[i][15:0];
                        end
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                acc_q[i]  <= '0;
                bias_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            for (int i = 0; i < 3; i++) begin
                acc_q[i]  <= acc_d[i];
                bias_q[i] <= bias_d[i];
            end
        end
    end

    assign bias_x     = bias_q[0];
    assign bias_y     = bias_q[1];
    assign bias_z     = bias_q[2];
    assign calib_busy = (state_q == ST_CALIB);
    assign calib_done = done_q;
    assign calib_fail = fail_q;

endmodule

// File: rtl/mpu_sample_unpack.sv
// Unpacks the MPU burst into signed words, applies gyro
// bias with saturation and watches for stale sensor data.
module mpu_sample_unpack
    import mpu_pkg::*;
#(
    parameter int CALIB_SHIFT  = 8,
    parameter int STALE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    mpu_sample_unpack_if.slave rd,
    input  logic               calib_start,
    output sample_t            accel_x,
    output sample_t            accel_y,
    output sample_t            accel_z,
    output sample_t            temp_raw,
    output sample_t            gyro_x,
    output sample_t            gyro_y,
    output sample_t            gyro_z,
    output logic               sample_valid,
    output logic               calib_busy,
    output logic               calib_done,
    output logic               calib_fail,
    output logic               data_stale
);

    localparam int WDW = $clog2(STALE_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(STALE_CYCLES);

    sample_t raw_q [MPU_WORDS];
    sample_t raw_d [MPU_WORDS];
    sample_t out_q [MPU_WORDS];
    sample_t out_d [MPU_WORDS];
    sample_t bias [3];

    logic s1_valid_q, s1_start_q, s1_error_q;
    logic valid_q, valid_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic stale_q, stale_d;

    // Start and error ride alongside stage 1 so the FSM
    // sees them in the same order as the samples.
    mpu_gyro_calib #(
        .CALIB_SHIFT (CALIB_SHIFT)
    ) u_calib (
        .clk        (clk),
        .rst_n      (rst_n),
        .smp_valid  (s1_valid_q),
        .start      (s1_start_q),
        .error      (s1_error_q),
        .gx         (raw_q[IDX_GX]),
        .gy         (raw_q[IDX_GY]),
        .gz         (raw_q[IDX_GZ]),
        .bias_x     (bias[0]),
        .bias_y     (bias[1]),
        .bias_z     (bias[2]),
        .calib_busy (calib_busy),
        .calib_done (calib_done),
        .calib_fail (calib_fail)
    );

    always_comb begin
        for (int i = 0; i < MPU_WORDS; i++) begin
            raw_d[i] = rd.mpu_read_done
                     ? mpu_word(rd.mpu_data_pack, i)
                     : raw_q[i];
        end
    end

    always_comb begin
        valid_d = s1_valid_q && !calib_busy;
        for (int i = 0; i < MPU_WORDS; i++) out_d[i] = out_q[i];
        if (valid_d) begin
            for (int i = 0; i < IDX_GX; i++) out_d[i] = raw_q[i];
            for (int k = 0; k < 3; k++) begin
                out_d[IDX_GX+k] = sat16(17'(raw_q[IDX_GX+k])
                                      - 17'(bias[k]));
            end
        end
    end

    always_comb begin
        if (rd.mpu_read_done) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WDW'(1);
        end
        stale_d = (wd_d == WD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_start_q <= 1'b0;
            s1_error_q <= 1'b0;
            valid_q    <= 1'b0;
            wd_q       <= WD_MAX;
            stale_q    <= 1'b1;
            for (int i = 0; i < MPU_WORDS; i++) begin
                raw_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= rd.mpu_read_done;
            s1_start_q <= calib_start;
            s1_error_q <= rd.mpu_error;
            valid_q    <= valid_d;
            wd_q       <= wd_d;
            stale_q    <= stale_d;
            for (int i = 0; i < MPU_WORDS; i++) begin
                raw_q[i] <= raw_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

    assign accel_x      = out_q[IDX_AX];
    assign accel_y      = out_q[IDX_AY];
    assign accel_z      = out_q[IDX_AZ];
    assign temp_raw     = out_q[IDX_TEMP];
    assign gyro_x       = out_q[IDX_GX];
    assign gyro_y       = out_q[IDX_GY];
    assign gyro_z       = out_q[IDX_GZ];
    assign sample_valid = valid_q;
    assign data_stale   = stale_q;

endmodule

// File: tb/tb_mpu_sample_unpack.sv
// Bench for mpu_sample_unpack: directed scenarios plus
// random traffic checked against a behavioural model.
module tb_mpu_sample_unpack;
    import mpu_pkg::*;

    localparam int CS    = 2;
    localparam int STALE = 16;
    localparam int NCAL  = 1 << CS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic calib_start = 1'b0;
    sample_t accel_x, accel_y, accel_z, temp_raw;
    sample_t gyro_x, gyro_y, gyro_z;
    logic sample_valid, calib_busy, calib_done;
    logic calib_fail, data_stale;

    mpu_sample_unpack_if rd_if ();

    mpu_sample_unpack #(
        .CALIB_SHIFT  (CS),
        .STALE_CYCLES (STALE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd           (rd_if),
        .calib_start  (calib_start),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .temp_raw     (temp_raw),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .sample_valid (sample_valid),
        .calib_busy   (calib_busy),
        .calib_done   (calib_done),
        .calib_fail   (calib_fail),
        .data_stale   (data_stale)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state.
    bit m_cal = 1'b0;
    int m_sum [3];
    int m_n = 0;
    int m_bias [3];
    int exp_q [$];
    int exp_done = 0, exp_fail = 0;
    int obs_done = 0, obs_fail = 0;
    int since = STALE;
    bit mon_en = 1'b0;
    int last_w [7];
    string nm [7] = '{"accel_x", "accel_y", "accel_z", "temp_raw",
                      "gyro_x", "gyro_y", "gyro_z"};

    function automatic int word_of(input logic [111:0] p, input int i);
        int v;
        v = int'(p[16*i +: 8]) * 256 + int'(p[16*i+8 +: 8]);
        if (v >= 32768) v -= 65536;
        return v;
    endfunction

    function automatic int fdiv(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [111:0] rnd_pack();
        logic [111:0] p;
        for (int b = 0; b < 14; b++) p[8*b +: 8] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    function automatic logic [111:0] put_word(
        input logic [111:0] p, input int i, input int v);
        logic [15:0] u;
        logic [111:0] r;
        u = 16'(v);
        r = p;
        r[16*i +: 8]   = u[15:8];
        r[16*i+8 +: 8] = u[7:0];
        return r;
    endfunction

    task automatic model(input bit rd, input logic [111:0] p,
                         input bit err, input bit st);
        int g [3];
        for (int k = 0; k < 3; k++) g[k] = word_of(p, 4 + k);
        if (!m_cal) begin
            if (rd) begin
                for (int i = 0; i < 4; i++) exp_q.push_back(word_of(p, i));
                for (int k = 0; k < 3; k++)
                    exp_q.push_back(clamp16(g[k] - m_bias[k]));
            end
            if (st) begin
                m_cal = 1'b1;
                m_n = 0;
                for (int k = 0; k < 3; k++) m_sum[k] = 0;
            end
        end else if (err) begin
            m_cal = 1'b0;
            exp_fail++;
        end else if (st) begin
            m_n = 0;
            for (int k = 0; k < 3; k++) m_sum[k] = 0;
        end else if (rd) begin
            for (int k = 0; k < 3; k++) m_sum[k] += g[k];
            m_n++;
            if (m_n == NCAL) begin
                for (int k = 0; k < 3; k++) m_bias[k] = fdiv(m_sum[k], NCAL);
                exp_done++;
                m_cal = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit rd, input logic [111:0] p,
                       input bit err, input bit st);
        model(rd, p, err, st);
        rd_if.mpu_read_done = rd;
        rd_if.mpu_data_pack = p;
        rd_if.mpu_error     = err;
        calib_start         = st;
        @(posedge clk);
        #1;
        since = rd ? 0 : (since < STALE ? since + 1 : STALE);
        chk("data_stale", int'(data_stale), int'(since == STALE));
        rd_if.mpu_read_done = 1'b0;
        rd_if.mpu_error     = 1'b0;
        calib_start         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic smp(input int gx, input int gy, input int gz,
                       input bit err);
        logic [111:0] p;
        p = rnd_pack();
        p = put_word(p, 4, gx);
        p = put_word(p, 5, gy);
        p = put_word(p, 6, gz);
        cyc(1'b1, p, err, 1'b0);
        idle(1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        rd_if.mpu_read_done = 1'b0;
        rd_if.mpu_data_pack = '0;
        rd_if.mpu_error = 1'b0;
        calib_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_cal = 1'b0;
        m_n = 0;
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0;
            m_bias[k] = 0;
        end
        exp_q.delete();
        since = STALE;
        chk("rst_accel_x", int'(accel_x), 0);
        chk("rst_temp", int'(temp_raw), 0);
        chk("rst_gyro_z", int'(gyro_z), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(calib_busy), 0);
        chk("rst_done", int'(calib_done), 0);
        chk("rst_stale", int'(data_stale), 1);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        int got [7];
        if (mon_en) begin
            if (calib_done) obs_done++;
            if (calib_fail) obs_fail++;
            if (sample_valid) begin
                chk("valid_expected", int'(exp_q.size() >= 7), 1);
                if (exp_q.size() >= 7) begin
                    got[0] = int'(accel_x);
                    got[1] = int'(accel_y);
                    got[2] = int'(accel_z);
                    got[3] = int'(temp_raw);
                    got[4] = int'(gyro_x);
                    got[5] = int'(gyro_y);
                    got[6] = int'(gyro_z);
                    for (int i = 0; i < 7; i++) begin
                        chk(nm[i], got[i], exp_q.pop_front());
                        last_w[i] = got[i];
                    end
                end
            end
        end
    end

    initial begin
        logic [111:0] p;
        logic [111:0] p2;
        do_reset();

        // Unpack
        p = '0;
        p[7:0]   = 8'h12;
        p[15:8]  = 8'h34;
        p[71:64] = 8'hFF;
        p[79:72] = 8'h9C;
        cyc(1'b1, p, 1'b0, 1'b0);
        idle(1);
        chk("unpack_valid_n2", int'(sample_valid), 1);
        idle(2);
        chk("unpack_ax", last_w[0], 32'h1234);
        chk("unpack_gx", last_w[4], -100);

        // Calibration
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle(2);
        chk("cal_busy", int'(calib_busy), 1);
        smp(100, 7, -3, 1'b0);
        smp(102, 9, -5, 1'b0);
        smp(98, 11, 0, 1'b0);
        smp(100, 13, 4, 1'b0);
        idle(3);
        chk("cal_done_cnt", obs_done, 1);
        chk("cal_busy_end", int'(calib_busy), 0);
        smp(150, 0, 0, 1'b0);
        idle(3);
        chk("cal_gx", last_w[4], 50);

        // Saturation
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NCAL; i++) smp(0, 100, 0, 1'b0);
        idle(2);
        smp(0, -32760, 0, 1'b0);
        idle(3);
        chk("sat_neg", last_w[5], -32768);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NCAL; i++) smp(0, -100, 0, 1'b0);
        idle(2);
        smp(0, 32760, 0, 1'b0);
        idle(3);
        chk("sat_pos", last_w[5], 32767);

        // Abort
        cyc(1'b0, '0, 1'b0, 1'b1);
        smp(5, 5, 5, 1'b0);
        smp(9, 9, 9, 1'b1);
        idle(3);
        chk("abort_fail_cnt", obs_fail, 1);
        chk("abort_busy", int'(calib_busy), 0);
        smp(0, 0, 0, 1'b0);
        idle(3);
        chk("abort_gy_keep", last_w[5], 100);

        // Watchdog
        idle(STALE + 4);
        cyc(1'b1, rnd_pack(), 1'b0, 1'b0);
        idle(3);

        // Back-to-back
        p  = rnd_pack();
        p2 = rnd_pack();
        cyc(1'b1, p, 1'b0, 1'b0);
        cyc(1'b1, p2, 1'b0, 1'b0);
        chk("b2b_valid1", int'(sample_valid), 1);
        idle(1);
        chk("b2b_valid2", int'(sample_valid), 1);
        idle(3);
        chk("b2b_ax2", last_w[0], word_of(p2, 0));

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 1)), rnd_pack(),
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 29) == 0);
        end
        idle(4);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle(4);

        // Reset mid-calibration
        cyc(1'b0, '0, 1'b0, 1'b1);
        smp(77, 77, 77, 1'b0);
        do_reset();
        smp(500, -7, 3, 1'b0);
        idle(3);
        chk("rst_bias_gx", last_w[4], 500);

        idle(4);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_total", obs_done, exp_done);
        chk("fail_total", obs_fail, exp_fail);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mpu_sample_unpack.md
Name: mpu_sample_unpack

Overview:
- Downstream consumer of the MPU I2C reader. On each single-cycle `mpu_read_done` pulse it latches the 112-bit burst read from register 0x3B onward.
- It reassembles the burst into seven signed 16-bit words: accel XYZ, temperature, gyro XYZ.
- It subtracts a runtime-calibrated gyro bias and saturates the result.
- Calibrated samples go to the attitude/control stage with a valid strobe; a data-stale watchdog flags loss of sensor updates.

Parameters:
- CALIB_SHIFT, 8, log2 of the number of samples averaged for gyro bias (2^8 = 256 samples).
- STALE_CYCLES, 500000, clk cycles without `mpu_read_done` before `data_stale` asserts (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- mpu_read_done  in  1  single-cycle pulse; `mpu_data_pack` is valid in that cycle
- mpu_data_pack  in  112  burst bytes; byte k is in [8k+7:8k], byte 0 = ACCEL_XOUT_H
- mpu_error  in  1  I2C error level from the reader
- calib_start  in  1  single-cycle pulse that starts gyro bias calibration
- accel_x, accel_y, accel_z  out  16  signed raw accelerometer values
- temp_raw  out  16  signed raw temperature
- gyro_x, gyro_y, gyro_z  out  16  signed, bias-corrected, saturated gyro values
- sample_valid  out  1  single-cycle strobe; all data outputs are updated in that cycle
- calib_busy  out  1  high while in CALIB
- calib_done  out  1  single-cycle pulse when a new bias has been committed
- calib_fail  out  1  single-cycle pulse when calibration is aborted by `mpu_error`
- data_stale  out  1  high when no `mpu_read_done` has occurred for STALE_CYCLES cycles

Behaviour:
- Reset: all data outputs, biases, accumulators and strobes = 0; `data_stale` = 1; state = RUN.

Word assembly:
- Word i = {pack[16i+7:16i], pack[16i+15:16i+8]}, i.e. the high byte comes first in the burst.
- Word order: 0=AX, 1=AY, 2=AZ, 3=TEMP, 4=GX, 5=GY, 6=GZ.

Pipeline:
- Stage 1: raw words are registered on the cycle after `mpu_read_done`.
- Stage 2: gyro correction is computed as 17-bit signed (raw − bias), saturated to [−32768, 32767], and all outputs are registered.
- `sample_valid` pulses 2 cycles after `mpu_read_done`.
- Accel and temp pass through unmodified, with latency equal to gyro.
- Back-to-back `mpu_read_done` pulses one cycle apart must each produce their own `sample_valid`; the pipeline is fully pipelined with no stalls.

State machine: RUN, CALIB.
- RUN:
  - Every sample is output with the current bias.
  - `calib_start` → CALIB: clear the three accumulators (signed, 16+CALIB_SHIFT bits) and the sample counter.
- CALIB:
  - Each stage-1 sample adds raw gx/gy/gz to the accumulators and increments the counter.
  - `sample_valid` is suppressed; data outputs hold their last values.
  - When the counter reaches 2^CALIB_SHIFT: bias = accumulator >>> CALIB_SHIFT (arithmetic shift, truncation toward −inf); pulse `calib_done` in that cycle; return to RUN.
  - `mpu_error` high in any cycle → abort, keep the previous bias, pulse `calib_fail`, go to RUN.
  - `calib_start` while in CALIB restarts calibration: accumulators and counter cleared.

Simultaneous events:
- `calib_start` and a sample in the same cycle: the sample is handled by the pre-transition state (in RUN: output with the old bias; not accumulated).
- Error and the final calibration sample in the same cycle: the error wins and the bias is not updated.
- Bias commit and the next sample in RUN: the sample after the commit cycle uses the new bias.

Watchdog:
- The counter resets to 0 on `mpu_read_done` and otherwise counts up, saturating at STALE_CYCLES.
- `data_stale` = (counter == STALE_CYCLES), registered.
- `data_stale` clears the cycle after `mpu_read_done`.
- `mpu_error` does not affect the watchdog.

Reset mid-calibration:
- Returns to RUN with bias 0; no strobes are emitted.

Decomposition:
- Package `mpu_pkg`:
  - Word index constants: IDX_AX … IDX_GZ.
  - MPU_BURST_BYTES = 14.
  - Signed 16-bit sample typedef.
  - Saturating 17→16-bit function.
- Sub-module `mpu_gyro_calib`:
  - Owns the accumulators, sample counter, bias registers and the CALIB/RUN FSM.
  - Exposes bias_x/y/z, calib_busy, calib_done and calib_fail.

Test Plan:
- Unpack: after reset, drive a pack with byte0=0x12, byte1=0x34, byte8=0xFF, byte9=0x9C, with `mpu_read_done` at cycle N → `sample_valid` at N+2; accel_x=0x1234; gyro_x=−100; `data_stale` drops to 0.
- Calibration (CALIB_SHIFT=2): `calib_start`, then 4 samples with gyro_x = 100, 102, 98, 100 → no `sample_valid`, `calib_done` pulses once; next sample gyro_x=150 → output 50.
- Saturation: calibrate gyro_y bias = 100, then raw gyro_y = −32760 → output −32768; bias −100 with raw 32760 → output 32767.
- Abort: `mpu_error` pulse during the 2nd calibration sample → `calib_fail` pulses, bias stays at the prior value, `calib_busy` drops, the next sample is output normally.
- Watchdog (STALE_CYCLES=16): no `mpu_read_done` for 16 cycles → `data_stale` = 1; one `mpu_read_done` → `data_stale` = 0 on the next cycle.
- Back-to-back: `mpu_read_done` in consecutive cycles with distinct packs → two consecutive `sample_valid` strobes with the matching values, in order.
